// File: rtl/fifo_drain_pkg.sv
// Shared types and helpers for the FIFO burst drain engine.
package fifo_drain_pkg;

  // Burst engine control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the two-bit completion status
  localparam int STAT_CORR   = 0;
  localparam int STAT_UNCORR = 1;
  localparam int STAT_W      = 2;

  // Sticky accumulation of the per-word ECC flags into the burst status
  function automatic logic [STAT_W-1:0] acc_status(
    input logic [STAT_W-1:0] cur,
    input logic              corr,
    input logic              det
  );
    logic [STAT_W-1:0] res;
    res              = cur;
    res[STAT_CORR]   = cur[STAT_CORR]   | corr;
    res[STAT_UNCORR] = cur[STAT_UNCORR] | det;
    return res;
  endfunction

endpackage

// File: rtl/handshake_reg_slice.sv
// Single-entry REQ/ACK register stage. The upstream side loads a word only
// when o_ready is high; the word is held stable until the downstream ACK.
module handshake_reg_slice #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         async_rst_n,
  input  logic         clk_en,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ack,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Slot occupancy and payload; a load in the same cycle as an ACK refills
  // the slot so the valid bit never drops between back-to-back words.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clk_en) begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (r_valid && i_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ready = !r_valid || i_ack;

endmodule

// File: rtl/fifo_burst_drain.sv
// Burst drain engine: accepts {base, length}, pops that many words from a
// first-word-fall-through FIFO and writes each one to an addressed memory
// port, then reports word count and sticky ECC status on a completion port.
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int ADDR_STRIDE = 4
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              clk_en,
  // command port
  input  logic              CmdREQ,
  output logic              CmdACK,
  input  logic [ADDR_W-1:0] CmdAddr,
  input  logic [LEN_W-1:0]  CmdLen,
  // FIFO read port
  input  logic              FifoREQ,
  output logic              FifoACK,
  input  logic [WIDTH-1:0]  FifoData,
  input  logic              FifoCorrectedECC,
  input  logic              FifoDetectedECC,
  // memory write port
  output logic              MemREQ,
  input  logic              MemACK,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [WIDTH-1:0]  MemData,
  // completion port
  output logic              DoneREQ,
  input  logic              DoneACK,
  output logic [LEN_W-1:0]  DoneCount,
  output logic [STAT_W-1:0] DoneStatus
);

  localparam int SLOT_W = ADDR_W + WIDTH;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_remaining;
  logic [LEN_W-1:0]    r_count;
  logic [STAT_W-1:0]   r_status;

  logic                w_cmd_xfer;
  logic                w_fifo_xfer;
  logic                w_mem_xfer;
  logic                w_done_xfer;
  logic                w_slot_valid;
  logic                w_slot_ready;
  logic [SLOT_W-1:0]   w_slot_data;
  logic                w_cmd_ack;
  logic                w_fifo_ack;
  logic                w_done_req;

  // Handshake completions; FifoACK already carries clk_en.
  assign w_cmd_xfer  = CmdREQ && w_cmd_ack && clk_en;
  assign w_fifo_xfer = FifoREQ && w_fifo_ack;
  assign w_mem_xfer  = w_slot_valid && MemACK && clk_en;
  assign w_done_xfer = w_done_req && DoneACK && clk_en;

  // Next-state and handshake outputs of the burst controller
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ack   = 1'b0;
    w_fifo_ack  = 1'b0;
    w_done_req  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ack = 1'b1;
        if (w_cmd_xfer) begin
          w_state_nxt = (CmdLen == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        // Pop only into a slot that is empty or draining this cycle.
        w_fifo_ack = clk_en && (r_remaining != '0) && w_slot_ready;
        // Last word has left the slot and nothing is left to fetch.
        if (w_mem_xfer && (r_remaining == '0)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done_req = 1'b1;
        if (w_done_xfer) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch side: address pointer, words left to pop and sticky ECC status
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_status    <= '0;
    end else if (clk_en) begin
      if (w_cmd_xfer) begin
        r_addr      <= CmdAddr;
        r_remaining <= CmdLen;
        r_status    <= '0;
      end else if (w_fifo_xfer) begin
        // Address wraps silently at 2^ADDR_W.
        r_addr      <= r_addr + ADDR_W'(ADDR_STRIDE);
        r_remaining <= r_remaining - LEN_W'(1);
        r_status    <= acc_status(r_status, FifoCorrectedECC, FifoDetectedECC);
      end
    end
  end

  // Write side: count of words accepted by memory
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_count <= '0;
    end else if (clk_en) begin
      if (w_cmd_xfer) begin
        r_count <= '0;
      end else if (w_mem_xfer) begin
        r_count <= r_count + LEN_W'(1);
      end
    end
  end

  // Output slot carrying {address, data} toward the memory port
  handshake_reg_slice #(
    .W (SLOT_W)
  ) u_slot (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .i_load      (w_fifo_xfer),
    .i_data      ({r_addr, FifoData}),
    .i_ack       (MemACK),
    .o_valid     (w_slot_valid),
    .o_data      (w_slot_data),
    .o_ready     (w_slot_ready)
  );

  assign CmdACK     = w_cmd_ack;
  assign FifoACK    = w_fifo_ack;
  assign MemREQ     = w_slot_valid;
  assign MemAddr    = w_slot_data[SLOT_W-1:WIDTH];
  assign MemData    = w_slot_data[WIDTH-1:0];
  assign DoneREQ    = w_done_req;
  assign DoneCount  = r_count;
  assign DoneStatus = r_status;

endmodule
